// File: rtl/as2650_bus_ctrl_pkg.sv
// Shared definitions for the AS2650 external bus controller: state and grant
// encodings, latched request record, timeout limit and the arbitration rule.
package as2650_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_SETUP  = 2'd1,
        BUS_STROBE = 2'd2,
        BUS_DONE   = 2'd3
    } bus_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_t;

    localparam int TIMEOUT_LIMIT = 255;
    localparam int WAIT_W        = 4;
    localparam int TO_W          = 8;

    typedef struct packed {
        grant_t     owner;
        logic       rw;
        logic       m_io;
        logic [7:0] wdata;
    } req_t;

    // On a tie the requester that did not win last time gets the bus.
    function automatic grant_t pick_winner(input logic cpu, input logic dma, input grant_t last);
        if (cpu && dma)
            return (last == GNT_DMA) ? GNT_CPU : GNT_DMA;
        else if (dma)
            return GNT_DMA;
        else
            return GNT_CPU;
    endfunction

endpackage

// File: rtl/as2650_bus_ctrl_wait_timer.sv
// Loadable saturating down-counter with a zero flag; used for strobe wait
// states and, when enabled, the bus timeout.
module as2650_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/as2650_bus_ctrl.sv
// AS2650 external bus cycle controller: CPU/DMA arbitration and
// setup/strobe/done sequencing. Optional timeout via AS2650_BUS_TIMEOUT_EN.
module as2650_bus_ctrl
    import as2650_bus_ctrl_pkg::*;
#(
    parameter int ADR_W    = 13,
    parameter int WAIT_MEM = 1,
    parameter int WAIT_IO  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_opreq,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic             cpu_rw,
    input  logic             cpu_m_io,
    input  logic [7:0]       cpu_wdata,
    output logic [7:0]       cpu_rdata,
    output logic             cpu_opack,
    input  logic             dma_req,
    input  logic [ADR_W-1:0] dma_adr,
    input  logic             dma_rw,
    input  logic [7:0]       dma_wdata,
    output logic [7:0]       dma_rdata,
    output logic             dma_gnt,
    output logic             dma_done,
    output logic [ADR_W-1:0] ext_adr,
    output logic [7:0]       ext_dout,
    input  logic [7:0]       ext_din,
    output logic             ext_oeb,
    output logic             ext_rw,
    output logic             ext_m_io,
    output logic             ext_opreq,
    output logic             ext_wrp,
    input  logic             ext_opack,
    output logic             bus_err
);

    bus_state_t        state, state_next;
    grant_t            last_grant, win;
    req_t              lat;
    logic [ADR_W-1:0]  lat_adr;
    logic              first_strobe;
    logic              bus_err_q;
    logic              wait_zero;
    logic              done_ok;
    logic              timeout_hit;
    logic              in_setup, in_strobe;
    logic [WAIT_W-1:0] wait_load;

    assign in_setup  = (state == BUS_SETUP);
    assign in_strobe = (state == BUS_STROBE);
    assign wait_load = lat.m_io ? WAIT_W'(WAIT_MEM) : WAIT_W'(WAIT_IO);
    assign done_ok   = in_strobe && wait_zero && ext_opack;

    as2650_wait_timer #(.W(WAIT_W)) u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (in_setup),
        .load_val (wait_load),
        .en       (in_strobe),
        .zero     (wait_zero)
    );

`ifdef AS2650_BUS_TIMEOUT_EN
    logic to_zero;

    // Loaded with limit-1 so the flag rises on the 255th strobe cycle.
    as2650_wait_timer #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (in_setup),
        .load_val (TO_W'(TIMEOUT_LIMIT - 1)),
        .en       (in_strobe),
        .zero     (to_zero)
    );

    assign timeout_hit = in_strobe && to_zero && !done_ok;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        win        = pick_winner(cpu_opreq, dma_req, last_grant);
        case (state)
            BUS_IDLE:   if (cpu_opreq || dma_req) state_next = BUS_SETUP;
            BUS_SETUP:  state_next = BUS_STROBE;
            BUS_STROBE: if (done_ok || timeout_hit) state_next = BUS_DONE;
            BUS_DONE:   state_next = BUS_IDLE;
            default:    state_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= BUS_IDLE;
            last_grant   <= GNT_DMA;
            lat          <= '0;
            lat_adr      <= '0;
            first_strobe <= 1'b0;
            cpu_rdata    <= 8'h00;
            dma_rdata    <= 8'h00;
            bus_err_q    <= 1'b0;
        end else begin
            state        <= state_next;
            first_strobe <= in_setup;
            if ((state == BUS_IDLE) && (cpu_opreq || dma_req)) begin
                last_grant <= win;
                lat.owner  <= win;
                if (win == GNT_CPU) begin
                    lat_adr   <= cpu_adr;
                    lat.rw    <= cpu_rw;
                    lat.m_io  <= cpu_m_io;
                    lat.wdata <= cpu_wdata;
                end else begin
                    lat_adr   <= dma_adr;
                    lat.rw    <= dma_rw;
                    lat.m_io  <= 1'b1;
                    lat.wdata <= dma_wdata;
                end
            end
            if (done_ok && !lat.rw) begin
                if (lat.owner == GNT_CPU) cpu_rdata <= ext_din;
                else                      dma_rdata <= ext_din;
            end else if (timeout_hit) begin
                if (lat.owner == GNT_CPU) cpu_rdata <= 8'hFF;
                else                      dma_rdata <= 8'hFF;
                bus_err_q <= 1'b1;
            end
        end
    end

    assign ext_adr   = lat_adr;
    assign ext_dout  = lat.wdata;
    assign ext_rw    = lat.rw;
    assign ext_m_io  = lat.m_io;
    assign ext_opreq = in_strobe;
    assign ext_wrp   = first_strobe && lat.rw;
    assign ext_oeb   = !(lat.rw && (in_setup || in_strobe));
    assign cpu_opack = (state == BUS_DONE) && (lat.owner == GNT_CPU);
    assign dma_done  = (state == BUS_DONE) && (lat.owner == GNT_DMA);
    assign dma_gnt   = (state != BUS_IDLE) && (lat.owner == GNT_DMA);
    assign bus_err   = bus_err_q;

endmodule
